// File: rtl/ymem_stage.sv
// Memory-access stage: one load/store per accepted request over a req/ack bus, with lane formatting.
// Optional bus timeout abort is enabled with `define YMEM_TIMEOUT_EN.
module ymem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        timed_out;

  logic        is_store;
  logic        is_load;
  logic        misaligned;
  logic        bad_f3;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ex_ready = (state == S_IDLE);
  assign bus_req  = (state == S_REQ);
  assign wb_valid = (state == S_RESP);

  // Read+write together is a store; neither means pass-through.
  always_comb begin
    is_store   = mem_write;
    is_load    = mem_read & ~mem_write;
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    if (is_store) bad_f3 = !(funct3 inside {3'b000, 3'b001, 3'b010});
    else          bad_f3 = (funct3 inside {3'b011, 3'b110, 3'b111});
    case (funct3[1:0])
      2'b00: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_n = addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = bus_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      3'b010:  ld_data = bus_rdata;
      default: ld_data = 32'h0;
    endcase
  end

`ifdef YMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  logic          err_q;

  // Expiry is decided on the edge that would make the count reach TIMEOUT.
  assign timed_out = (state == S_REQ) && !bus_ack && (cnt == LAST);
  assign bus_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (state == S_IDLE)          cnt <= '0;
    else if (state == S_REQ && !bus_ack) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               err_q <= 1'b0;
    else if (timed_out)       err_q <= 1'b1;
    else if (state == S_RESP) err_q <= 1'b0;
  end
`else
  assign timed_out = 1'b0;
  assign bus_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_be    <= 4'h0;
      wb_data   <= 32'h0;
      fault     <= 1'b0;
      f3_q      <= 3'b0;
      lane_q    <= 2'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            if (!is_store && !is_load) begin
              wb_data <= addr;
              state   <= S_RESP;
            end else if (misaligned || bad_f3) begin
              wb_data <= 32'h0;
              fault   <= 1'b1;
              state   <= S_RESP;
            end else begin
              bus_we    <= is_store;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wdata <= wd_n;
              bus_be    <= be_n;
              f3_q      <= funct3;
              lane_q    <= addr[1:0];
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            wb_data <= bus_we ? 32'h0 : ld_data;
            bus_we  <= 1'b0;
            bus_be  <= 4'h0;
            state   <= S_RESP;
          end else if (timed_out) begin
            wb_data <= 32'h0;
            bus_we  <= 1'b0;
            bus_be  <= 4'h0;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          fault <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ymem_stage.sv
// Bench for ymem_stage: directed accesses, an access-level model, and a per-cycle write-back checker.
module tb_ymem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        fault;
  logic        bus_err;

  int total = 0;
  int bad = 0;
  logic bus_open = 1'b0;
  logic [31:0] exp_q[$];
  logic [1:0]  flag_q[$];

  ymem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .addr(addr), .wdata(wdata), .funct3(funct3), .mem_read(mem_read),
    .mem_write(mem_write), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .fault(fault), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Access-level model: size in bytes, alignment by modulo, data by shift/mask.
  task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                       input logic rd, input logic wr, input logic [31:0] rdata,
                       output logic m_bus, output logic [3:0] m_be, output logic [31:0] m_bw,
                       output logic [31:0] m_wb, output logic m_flt);
    int sz;
    logic legal;
    logic [31:0] v;
    logic [7:0] full_mask;
    sz = 1 << f3[1:0];
    m_bus = 0; m_be = 0; m_bw = 0; m_wb = 0; m_flt = 0;
    if (!rd && !wr) begin
      m_wb = a;
      return;
    end
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal || (a % sz) != 0) begin
      m_flt = 1;
      return;
    end
    m_bus = 1;
    full_mask = 8'((1 << sz) - 1);
    m_be = 4'(full_mask << (a % 4));
    for (int i = 0; i < 4; i++) m_bw[8*i +: 8] = wd[8*(i % sz) +: 8];
    if (!wr) begin
      v = rdata >> (8 * (a % 4));
      if (sz == 1) v = (!f3[2] && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'hFF);
      else if (sz == 2) v = (!f3[2] && v[15]) ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
      m_wb = v;
    end
  endtask

  // Write-back checker: every wb_valid must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req && !bus_open) chk("bus_req_unexpected", 32'(bus_req), 32'd0);
      if (wb_valid) begin
        if (exp_q.size() == 0) chk("wb_valid_unexpected", 32'(wb_valid), 32'd0);
        else begin
          logic [31:0] e;
          logic [1:0]  fl;
          e = exp_q.pop_front();
          fl = flag_q.pop_front();
          chk("wb_data", wb_data, e);
          chk("fault", 32'(fault), 32'(fl[0]));
          chk("bus_err", 32'(bus_err), 32'(fl[1]));
        end
      end
    end
  end

  // ack_k: REQ cycle (1-based) in which bus_ack is driven; 0 = never.
  task automatic run(input string nm, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input logic rd, input logic wr,
                     input int ack_k, input logic [31:0] rdata,
                     input logic [31:0] lit_wb, input logic [3:0] lit_be);
    logic m_bus, m_flt;
    logic [3:0] m_be;
    logic [31:0] m_bw, m_wb;
    int cyc, lat;
    logic done;
    model(a, wd, f3, rd, wr, rdata, m_bus, m_be, m_bw, m_wb, m_flt);
    chk({nm, "_model_wb"}, m_wb, lit_wb);
    if (m_bus) chk({nm, "_model_be"}, 32'(m_be), 32'(lit_be));
    lat = !m_bus ? 1 : (ack_k == 0 ? TO + 1 : ack_k + 1);
    @(negedge clk);
    chk({nm, "_ready_idle"}, 32'(ex_ready), 32'd1);
    ex_valid = 1; addr = a; wdata = wd; funct3 = f3; mem_read = rd; mem_write = wr;
    @(posedge clk);
    #1;
    ex_valid = 0; mem_read = 0; mem_write = 0; addr = $urandom; wdata = $urandom;
    exp_q.push_back(m_wb);
    flag_q.push_back({m_bus && ack_k == 0, m_flt});
    bus_open = m_bus;
    cyc = 1;
    done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (wb_valid) begin
        chk({nm, "_latency"}, 32'(cyc), 32'(lat));
        done = 1;
      end else if (bus_req) begin
        chk({nm, "_busy"}, 32'(ex_ready), 32'd0);
        chk({nm, "_bus_we"}, 32'(bus_we), 32'(wr));
        chk({nm, "_bus_addr"}, bus_addr, a & ~32'd3);
        chk({nm, "_bus_wdata"}, bus_wdata, m_bw);
        chk({nm, "_bus_be"}, 32'(bus_be), 32'(m_be));
        if (cyc == ack_k) begin
          bus_ack = 1;
          bus_rdata = rdata;
        end else bus_rdata = $urandom;
      end
      @(posedge clk);
      #1;
      if (bus_ack || (bus_open && !bus_req)) bus_open = 0;
      bus_ack = 0;
      cyc++;
    end
    if (!done) begin
      chk({nm, "_wb_timeout"}, 32'(cyc), 32'(lat));
      bus_open = 0;
    end else begin
      @(negedge clk);
      chk({nm, "_ready_after"}, 32'(ex_ready), 32'd1);
      chk({nm, "_wb_pulse"}, 32'(wb_valid), 32'd0);
      chk({nm, "_req_after"}, 32'(bus_req), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    #12;
    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we_be", {27'd0, bus_we, bus_be}, 32'd0);
    chk("rst_wb", {29'd0, wb_valid, fault, bus_err}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1;

    run("lw",   32'h100, 32'h0, 3'b010, 1, 0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
    run("lb",   32'h103, 32'h0, 3'b000, 1, 0, 1, 32'h80FF7F01, 32'hFFFFFF80, 4'b1000);
    run("lbu",  32'h103, 32'h0, 3'b100, 1, 0, 2, 32'h80FF7F01, 32'h00000080, 4'b1000);
    run("lh",   32'h102, 32'h0, 3'b001, 1, 0, 1, 32'h80FF7F01, 32'hFFFF80FF, 4'b1100);
    run("lhu",  32'h102, 32'h0, 3'b101, 1, 0, 2, 32'h80FF7F01, 32'h000080FF, 4'b1100);
    run("lb0",  32'h200, 32'h0, 3'b000, 1, 0, 1, 32'h80FF7F01, 32'h00000001, 4'b0001);
    run("sb",   32'h21,  32'h12345678, 3'b000, 0, 1, 2, 32'h0, 32'h0, 4'b0010);
    run("sh",   32'h22,  32'h12345678, 3'b001, 0, 1, 1, 32'h0, 32'h0, 4'b1100);
    run("sw_rw", 32'h40, 32'hA5A5_0F0F, 3'b010, 1, 1, 1, 32'hFFFFFFFF, 32'h0, 4'b1111);
    run("lw_mis", 32'h102, 32'h0, 3'b010, 1, 0, 1, 32'h0, 32'h0, 4'b0);
    run("sh_mis", 32'h101, 32'h0, 3'b001, 0, 1, 1, 32'h0, 32'h0, 4'b0);
    run("ld_f3",  32'h100, 32'h0, 3'b011, 1, 0, 1, 32'h0, 32'h0, 4'b0);
    run("st_f3",  32'h100, 32'h0, 3'b100, 0, 1, 1, 32'h0, 32'h0, 4'b0);
    run("pass",   32'hCAFE, 32'h0, 3'b010, 0, 0, 0, 32'h0, 32'hCAFE, 4'b0);

    // Reset while a load is waiting for its acknowledge.
    @(negedge clk);
    ex_valid = 1; addr = 32'h300; funct3 = 3'b010; mem_read = 1;
    bus_open = 1;
    @(posedge clk);
    #1;
    ex_valid = 0; mem_read = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_req_before", 32'(bus_req), 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("rst_mid_req", 32'(bus_req), 32'd0);
    chk("rst_mid_wb", 32'(wb_valid), 32'd0);
    chk("rst_mid_ready", 32'(ex_ready), 32'd1);
    bus_open = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_after_ready", 32'(ex_ready), 32'd1);
    end

    run("post_rst_lw", 32'h104, 32'h0, 3'b010, 1, 0, 1, 32'h01234567, 32'h01234567, 4'b1111);

`ifdef YMEM_TIMEOUT_EN
    run("timeout", 32'h400, 32'h0, 3'b010, 1, 0, 0, 32'h0, 32'h0, 4'b1111);
    run("ack_last", 32'h404, 32'h0, 3'b010, 1, 0, TO, 32'h55AA55AA, 32'h55AA55AA, 4'b1111);
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ymem_stage.md
# ymem_stage

Memory-access stage of the RISC-V datapath, sitting directly downstream of the execute stage. It takes the ALU result (address or pass-through value) plus store data and memory-control bits. It runs one load or store per accepted request over a request/acknowledge data-memory bus, and presents the write-back value to the register file. It formats byte, halfword and word accesses (lane steering, byte enables, sign/zero extension) and flags illegal accesses without touching the bus.

## Interface
Clock is `clk`; reset is asynchronous and active-low (`rst_n`).

Parameters:
- `TIMEOUT`, default 15: number of `bus_req` cycles without `bus_ack` before abort. Used only with `YMEM_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  execute stage presents a request
- `ex_ready`  out  1  stage idle, can accept
- `addr`  in  32  ALU result: byte address, or pass-through value
- `wdata`  in  32  store data (rd2)
- `funct3`  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- `mem_read`  in  1  load
- `mem_write`  in  1  store
- `bus_req`  out  1  bus request, held until acknowledged
- `bus_we`  out  1  1 = write
- `bus_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `bus_wdata`  out  32  lane-replicated store data
- `bus_be`  out  4  byte enables
- `bus_ack`  in  1  bus completes the access this cycle
- `bus_rdata`  in  32  read word, valid when `bus_ack`=1
- `wb_valid`  out  1  one-cycle pulse: `wb_data` valid
- `wb_data`  out  32  write-back value
- `fault`  out  1  misaligned access or unsupported funct3; qualified by `wb_valid`
- `bus_err`  out  1  bus timeout; qualified by `wb_valid`

## Operation
- FSM states: IDLE, REQ, RESP. `ex_ready` = (state == IDLE).
- Request fields are captured on accept (`ex_valid && ex_ready`).
- Accept with neither `mem_read` nor `mem_write` set: go to RESP with `wb_data`=`addr`; no bus access.
- Accept with both set: the access is treated as a store.
- Fault: halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or load funct3 ∈ {011,110,111}, or store funct3 ∉ {000,001,010}.
  - Go to RESP with `fault`=1 and `wb_data`=0; no bus access.
- Legal access: go to REQ. `bus_req`=1, and `bus_we`/`bus_addr`/`bus_wdata`/`bus_be` stay stable until the cycle `bus_ack`=1. Then go to RESP.
- Store data and enables:
  - sb: `bus_wdata`={4{wdata[7:0]}}, `bus_be`=4'b0001<<addr[1:0]
  - sh: `bus_wdata`={2{wdata[15:0]}}, `bus_be`=addr[1]?4'b1100:4'b0011
  - sw: `bus_wdata`=wdata, `bus_be`=4'b1111
- Loads select lane `addr[1:0]` from `bus_rdata`:
  - lb/lh sign-extend; lbu/lhu zero-extend; lw takes the full word.
- Load data is registered on the `bus_ack` cycle. A store returns `wb_data`=0.
- RESP: `wb_valid`=1 for exactly one cycle, then IDLE.
- `bus_ack` is ignored in IDLE and RESP.

## Timing
- Reset values: state IDLE, `ex_ready`=1, and `bus_req`, `bus_we`, `bus_be`, `wb_valid`, `fault`, `bus_err`=0. `bus_addr`, `bus_wdata`, `wb_data` are 0.
- Pass-through or fault: accept at edge N, `wb_valid` high in cycle N+1, `ex_ready` high again in cycle N+2.
- Bus access: accept at edge N, `bus_req` high from cycle N+1. If `bus_ack` is sampled at edge M, `bus_req` is low and `wb_valid` high in cycle M+1, and `ex_ready` is high in cycle M+2.
  - Minimum load/store latency: 2 cycles from accept to `wb_valid`.
- `bus_ack` in the first REQ cycle is legal. `bus_ack` is a single-cycle pulse per request.
- Reset asserted mid-operation: `bus_req` and `wb_valid` drop immediately (asynchronous). No `wb_valid` is produced for the aborted request.
- Back-to-back throughput: one request per 3 cycles minimum (pass-through: 2).

## Configuration
- `YMEM_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` is cleared on entry to REQ and increments each REQ cycle without `bus_ack`.
  - When it reaches `TIMEOUT`, `bus_req` drops next cycle and the FSM goes to RESP with `bus_err`=1, `wb_data`=0.
  - `bus_ack` in the same cycle as expiry wins: normal completion.
- `YMEM_TIMEOUT_EN` not defined: REQ waits indefinitely. `bus_err` is tied 0, and no counter logic is present.

## Test plan
- lw, `addr`=0x100, `bus_rdata`=0xDEADBEEF, ack in 3rd REQ cycle -> `bus_addr`=0x100, `bus_be`=1111, `wb_data`=0xDEADBEEF, `wb_valid` single pulse one cycle after ack.
- lb/lbu/lh/lhu, `addr`=0x103 (byte) and 0x102 (half), `bus_rdata`=0x80FF7F01 -> lb 0xFFFFFF80, lbu 0x00000080, lh 0xFFFF80FF, lhu 0x000080FF.
- sb `addr`=0x21, `wdata`=0x12345678 -> `bus_wdata`=0x78787878, `bus_be`=0010, `bus_we`=1; sh `addr`=0x22 -> `bus_wdata`=0x56785678, `bus_be`=1100.
- lw `addr`=0x102, and sh `addr`=0x101 -> `fault`=1, `wb_data`=0, `bus_req` never asserted. Pass-through with `addr`=0xCAFE -> `wb_data`=0xCAFE, `wb_valid` in cycle N+1.
- Deassert `rst_n` during REQ -> `bus_req`=0 the same cycle, no `wb_valid`, `ex_ready`=1 after release.
- With `YMEM_TIMEOUT_EN`, `TIMEOUT`=4, no ack -> `bus_req` high 4 cycles, then `wb_valid`=1 with `bus_err`=1; ack in the 4th cycle -> normal completion, `bus_err`=0.
